// File: rtl/edge_col.sv
// Column-streaming Sobel edge stage: holds a 3-column window (A left, B centre,
// incoming column right) and emits one thresholded edge-mask column per input column.
module edge_col #(
  parameter int              ROWS   = 256,
  parameter int              W      = 8,
  parameter logic [W+2:0]    THRESH = 11'd128
) (
  input  logic                 clock,
  input  logic                 init_n,
  input  logic                 data_rdy_in,
  input  logic [ROWS*W-1:0]    data_in,
  input  logic                 last_col_in,
  output logic                 data_req_out,
  input  logic                 data_req_in,
  output logic                 data_rdy_out,
  output logic [ROWS-1:0]      data_out,
  output logic                 last_col_out
);

  localparam int SW = W + 2;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_PRIMED = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t              state_q;
  logic [ROWS*W-1:0]   a_q;
  logic [ROWS*W-1:0]   b_q;
  logic                data_rdy_q;
  logic                last_col_q;
  logic [ROWS-1:0]     data_out_q;

  logic                out_free_s;
  logic                in_xfer_s;
  logic                out_xfer_s;
  logic [ROWS*W-1:0]   right_col_s;
  logic [ROWS-1:0]     edge_d;

  function automatic logic [W-1:0] pix_f(input logic [ROWS*W-1:0] col, input int r);
    return col[r*W +: W];
  endfunction

  // 1-2-1 weighted sum; the centre tap carries the double weight.
  function automatic logic [SW-1:0] wsum_f(input logic [W-1:0] p0, input logic [W-1:0] p1,
                                           input logic [W-1:0] p2);
    return {2'b00, p0} + {1'b0, p1, 1'b0} + {2'b00, p2};
  endfunction

  function automatic logic [SW-1:0] absdiff_f(input logic [SW-1:0] pos, input logic [SW-1:0] neg);
    logic signed [SW:0] g;
    logic signed [SW:0] ng;
    g  = $signed({1'b0, pos}) - $signed({1'b0, neg});
    ng = -g;
    if (g[SW]) begin
      return ng[SW-1:0];
    end else begin
      return g[SW-1:0];
    end
  endfunction

  // Per-row Sobel magnitude with replicate padding at the top and bottom rows.
  function automatic logic [ROWS-1:0] edge_f(input logic [ROWS*W-1:0] a,
                                             input logic [ROWS*W-1:0] b,
                                             input logic [ROWS*W-1:0] x);
    logic [ROWS-1:0] m;
    logic [SW-1:0]   sx, sa, sdn, sup;
    logic [SW:0]     mag;
    int              up, dn;
    m = '0;
    for (int r = 0; r < ROWS; r++) begin
      up  = (r == 0) ? 0 : r - 1;
      dn  = (r == ROWS - 1) ? r : r + 1;
      sx  = wsum_f(pix_f(x, up), pix_f(x, r), pix_f(x, dn));
      sa  = wsum_f(pix_f(a, up), pix_f(a, r), pix_f(a, dn));
      sdn = wsum_f(pix_f(a, dn), pix_f(b, dn), pix_f(x, dn));
      sup = wsum_f(pix_f(a, up), pix_f(b, up), pix_f(x, up));
      mag = {1'b0, absdiff_f(sx, sa)} + {1'b0, absdiff_f(sdn, sup)};
      m[r] = (mag >= THRESH);
    end
    return m;
  endfunction

  // Handshake qualifiers; the request is gated by reset combinationally.
  always_comb begin
    out_free_s   = ~data_rdy_q | data_req_in;
    data_req_out = 1'b0;
    if (init_n && out_free_s && (state_q == ST_EMPTY || state_q == ST_PRIMED)) begin
      data_req_out = 1'b1;
    end else begin
      data_req_out = 1'b0;
    end
    in_xfer_s  = data_req_out & data_rdy_in;
    out_xfer_s = data_rdy_q & data_req_in;
  end

  // In FLUSH the centre column stands in for the missing right column.
  always_comb begin
    right_col_s = data_in;
    if (state_q == ST_FLUSH) begin
      right_col_s = b_q;
    end else begin
      right_col_s = data_in;
    end
    edge_d = edge_f(a_q, b_q, right_col_s);
  end

  // Window/FSM/output registers; a same-cycle load overrides the output-drain clear.
  always_ff @(posedge clock) begin
    if (!init_n) begin
      state_q    <= ST_EMPTY;
      a_q        <= '0;
      b_q        <= '0;
      data_rdy_q <= 1'b0;
      last_col_q <= 1'b0;
      data_out_q <= '0;
    end else begin
      if (out_xfer_s) begin
        data_rdy_q <= 1'b0;
        last_col_q <= 1'b0;
      end
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer_s) begin
            a_q     <= data_in;
            b_q     <= data_in;
            state_q <= last_col_in ? ST_FLUSH : ST_PRIMED;
          end
        end
        ST_PRIMED: begin
          if (in_xfer_s) begin
            data_out_q <= edge_d;
            data_rdy_q <= 1'b1;
            last_col_q <= 1'b0;
            a_q        <= b_q;
            b_q        <= data_in;
            state_q    <= last_col_in ? ST_FLUSH : ST_PRIMED;
          end
        end
        ST_FLUSH: begin
          if (out_free_s) begin
            data_out_q <= edge_d;
            data_rdy_q <= 1'b1;
            last_col_q <= 1'b1;
            state_q    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_xfer_s) begin
            state_q <= ST_EMPTY;
          end
        end
        default: begin
          state_q    <= ST_EMPTY;
          data_rdy_q <= 1'b0;
          last_col_q <= 1'b0;
        end
      endcase
    end
  end

  assign data_rdy_out = data_rdy_q;
  assign last_col_out = last_col_q;
  assign data_out     = data_out_q;

endmodule

// File: doc/edge_col.md
Name: edge_col

Overview:
- Column-streaming Sobel edge stage sitting directly downstream of the greyscale column pipe.
- Accepts one greyscale column of ROWS pixels per transfer and keeps a 3-column sliding window.
- Emits one binary edge-mask column per input column, one column behind the input, using replicate padding at all image borders.
- The mask feeds the Hough voting stage using the same data_req/data_rdy/last_col handshake.

Parameters:
ROWS, 256, pixels per column
W, 8, greyscale pixel width (the arithmetic widths below assume W=8)
THRESH, 11'd128, gradient magnitude threshold; an edge is declared when mag >= THRESH

Ports:
clock  input  1  single clock, rising-edge
init_n  input  1  synchronous active-low reset
data_rdy_in  input  1  upstream column valid
data_in  input  ROWS x W  upstream greyscale column, row 0 first
last_col_in  input  1  data_in is the final column of the frame
data_req_out  output  1  this stage accepts a column this cycle
data_req_in  input  1  downstream accepts data_out this cycle
data_rdy_out  output  1  data_out valid
data_out  output  ROWS x 1  edge mask column
last_col_out  output  1  data_out is the final mask column of the frame

Behaviour:
- Clock and reset: one clock, `clock`. Reset `init_n` is synchronous and active-low.
- Reset values (init_n=0 at a clock edge):
  - state=EMPTY; data_rdy_out=0; last_col_out=0; data_out=0; window registers A,B=0.
  - data_req_out is forced to 0 combinationally while init_n=0.
- Transfers:
  - Input transfer: data_req_out & data_rdy_in.
  - Output transfer: data_rdy_out & data_req_in.
- Output slot availability: out_free = ~data_rdy_out | data_req_in.
- data_req_out = init_n & out_free & (state==EMPTY | state==PRIMED).
- Window: A = left column, B = centre column; the incoming column X is the right column.
- Row padding: row -1 uses row 0; row ROWS uses row ROWS-1.
- Per row r:
  - Gx = (X[r-1] + 2X[r] + X[r+1]) - (A[r-1] + 2A[r] + A[r+1]).
  - Gy = (A[r+1] + 2B[r+1] + X[r+1]) - (A[r-1] + 2B[r-1] + X[r-1]).
- Widths: weighted sums are 10-bit unsigned; Gx and Gy are 11-bit signed; |Gx| and |Gy| are 10-bit.
- Magnitude: mag = |Gx| + |Gy|, 11-bit unsigned (max 2040, no saturation needed).
- Output bit: data_out[r] = (mag >= THRESH).
- States:
  - EMPTY: on input transfer, A<=X, B<=X (left replicate).
    - last_col_in=1 -> FLUSH; else -> PRIMED.
    - No output is produced.
  - PRIMED: on input transfer, edge(A,B,X) is registered into data_out, data_rdy_out<=1, last_col_out<=0, then A<=B, B<=X.
    - last_col_in=1 -> FLUSH; else stay in PRIMED.
  - FLUSH: data_req_out=0. When out_free, edge(A,B,B) is registered (right replicate), data_rdy_out<=1, last_col_out<=1 -> DONE.
  - DONE: data_req_out=0. On output transfer: data_rdy_out<=0, last_col_out<=0 -> EMPTY.
- Output transfer with no new load in the same cycle: data_rdy_out<=0.
- Simultaneous output transfer and new load: the new column replaces the old one; data_rdy_out stays 1.
- Latency:
  - Mask for column k is registered on the edge that accepts column k+1.
  - The final column's mask is registered on the first edge in FLUSH with out_free.
- Throughput: one column per cycle when both sides are always ready.
- Frame size: N input columns produce exactly N output columns. N=1 is legal and gives a single output with last_col_out=1.
- Backpressure: while data_rdy_out=1 and data_req_in=0, data_out and last_col_out hold and no input is accepted.
- data_in and last_col_in are ignored when no input transfer occurs.
- Reset mid-frame: all state is discarded; the next accepted column is treated as column 0.

Test Plan:
- Uniform frame, 4 columns all pixels 100, both sides always ready -> 4 outputs, every data_out bit 0, last_col_out=1 only on the 4th; first data_rdy_out one cycle after the 2nd input transfer.
- Vertical step, 6 columns: cols 0-2 = 0, cols 3-5 = 255 -> output cols 2 and 3 all ones (Gx=1020, mag=1020); cols 0,1,4,5 all zeros.
- Horizontal step: rows 0-127 = 0, rows 128-255 = 200, 3 columns -> in every output column bits 127 and 128 are 1 (Gy=800), all other bits 0; rows 0 and 255 are 0 (padding).
- Single-column frame with last_col_in=1 and value 50 -> exactly one output, all zeros, last_col_out=1; state returns to EMPTY after the transfer; data_req_out=0 in FLUSH/DONE.
- Backpressure: data_req_in=0 for 5 cycles while data_rdy_out=1 -> data_req_out=0, data_out stable; on release, columns resume in order with none lost or duplicated (compare against a model on a 10-column random frame).
- Reset mid-frame: init_n=0 after 3 of 8 columns -> data_rdy_out=0, data_out=0, last_col_out=0 next cycle; a fresh 3-column frame then yields 3 outputs matching the model.
